// File: rtl/lsu_data_port_if.sv
// rtl/lsu_data_port_if.sv - request/response and data-memory signals of the load/store unit
interface lsu_data_port_if;
   // Core-side request
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   // Core-side response
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_misaligned;
   logic        rsp_fault;
   // Data memory
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_ctrl;
   logic        mem_wr_en;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
   logic        mem_available;

   // master: the environment (core memory stage plus data memory)
   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_available,
      input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault,
      input  mem_addr, mem_wdata, mem_ctrl, mem_wr_en, mem_rd_en
   );

   // slave: the load/store unit itself
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_available,
      output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault,
      output mem_addr, mem_wdata, mem_ctrl, mem_wr_en, mem_rd_en
   );
endinterface

// File: rtl/lsu_data_port.sv
// rtl/lsu_data_port.sv - load/store unit: checks, lane steering and load extension
module lsu_data_port #(
   parameter int unsigned ADDR_LIMIT = 65536
) (
   input logic            clk,
   input logic            rst_n,
   lsu_data_port_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, LOAD_DATA, RESP} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic        we_q, mis_q, flt_q;
   logic [2:0]  f3_q;

   logic        accept;
   logic        illegal_d, mis_d, flt_d;
   logic [2:0]  size_d;
   logic [32:0] end_addr_d;
   logic [3:0]  lane_ctrl;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_val;

   assign accept = bus.req_valid && (state_q == IDLE);

   // Classify the incoming request: illegal encoding, misalignment, then range
   always_comb begin
      case (bus.req_funct3[1:0])
         2'b00:   size_d = 3'd1;
         2'b01:   size_d = 3'd2;
         default: size_d = 3'd4;
      endcase
      illegal_d = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2] && bus.req_funct3[1])
               || (bus.req_we && bus.req_funct3[2]);
      mis_d = !illegal_d &&
              (((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)));
      // 33-bit sum so accesses near the top of the 32-bit space cannot wrap into range
      end_addr_d = {1'b0, bus.req_addr} + {30'b0, size_d};
      flt_d = illegal_d || (!mis_d && (end_addr_d > 33'(ADDR_LIMIT)));
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; memory stalls only hold the two memory-facing states
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (accept) state_d = (mis_d || flt_d) ? RESP : ACCESS;
         ACCESS:    if (bus.mem_available) state_d = we_q ? RESP : LOAD_DATA;
         LOAD_DATA: if (bus.mem_available) state_d = RESP;
         RESP:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Byte-lane strobes and load extraction from the registered request
   always_comb begin
      case (f3_q[1:0])
         2'b00:   lane_ctrl = 4'b0001 << addr_q[1:0];
         2'b01:   lane_ctrl = 4'b0011 << {addr_q[1], 1'b0};
         default: lane_ctrl = 4'b1111;
      endcase
      sel_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      sel_half = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
      case (f3_q)
         3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
         3'b100:  load_val = {24'b0, sel_byte};
         3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
         3'b101:  load_val = {16'b0, sel_half};
         default: load_val = bus.mem_rdata;
      endcase
   end

   // Request capture; response fields are reloaded on every acceptance so
   // error flags are already valid when an error goes straight to RESP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
         flt_q   <= 1'b0;
      end else if (accept) begin
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
         we_q    <= bus.req_we;
         f3_q    <= bus.req_funct3;
         rdata_q <= '0;
         mis_q   <= mis_d;
         flt_q   <= flt_d;
      end else if ((state_q == LOAD_DATA) && bus.mem_available) begin
         rdata_q <= load_val;
      end
   end

   assign bus.req_ready      = (state_q == IDLE);
   assign bus.rsp_valid      = (state_q == RESP);
   assign bus.rsp_rdata      = rdata_q;
   assign bus.rsp_misaligned = mis_q;
   assign bus.rsp_fault      = flt_q;
   assign bus.mem_addr       = {addr_q[31:2], 2'b00};
   assign bus.mem_wdata      = wdata_q << {addr_q[1:0], 3'b000};
   assign bus.mem_ctrl       = (state_q == ACCESS) ? lane_ctrl : 4'b0000;
   assign bus.mem_wr_en      = (state_q == ACCESS) && we_q;
   assign bus.mem_rd_en      = (state_q == ACCESS) && !we_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// tb/tb_lsu_data_port.sv - randomized and directed bench for lsu_data_port
module tb_lsu_data_port;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lsu_data_port_if bus ();

   lsu_data_port #(.ADDR_LIMIT(65536)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   bit [7:0] phys_mem [65536];
   bit [7:0] ref_mem  [65536];

   // Data memory: byte-lane writes, registered read word
   always @(posedge clk) begin
      if (bus.mem_wr_en && bus.mem_available)
         for (int k = 0; k < 4; k++)
            if (bus.mem_ctrl[k]) phys_mem[{bus.mem_addr[15:2], 2'(k)}] <= bus.mem_wdata[8*k +: 8];
      if (bus.mem_rd_en && bus.mem_available)
         bus.mem_rdata <= {phys_mem[{bus.mem_addr[15:2], 2'd3}], phys_mem[{bus.mem_addr[15:2], 2'd2}],
                           phys_mem[{bus.mem_addr[15:2], 2'd1}], phys_mem[{bus.mem_addr[15:2], 2'd0}]};
   end

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic        mis;
      logic        flt;
   } err_case_t;

   // Expected and observed results of the latest transaction
   logic [31:0] e_rdata, o_rdata, o_maddr, o_mwdata;
   logic        e_mis, e_flt, o_mis, o_flt, o_wr, o_rd, o_pulse_ok;
   logic [3:0]  o_mctrl;
   int          e_lat, o_lat, o_strobe_cycles, o_unstable, o_ready_busy;

   // Reference: byte-addressed memory with the access rules applied directly
   function automatic void ref_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, output logic [31:0] rd,
                                   output logic mis, output logic flt, output int lat);
      int size;
      logic illegal;
      longint a;
      logic [31:0] v;
      illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
      case (f3[1:0])
         2'b00:   size = 1;
         2'b01:   size = 2;
         default: size = 4;
      endcase
      a   = longint'({32'h0, addr});
      mis = !illegal && ((a % size) != 0);
      flt = illegal || (!mis && (a + size > 65536));
      rd  = '0;
      if (mis || flt) begin
         lat = 1;
      end else if (we) begin
         for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wdata[8*i +: 8];
         lat = 2;
      end else begin
         v = '0;
         for (int i = 0; i < size; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
         rd  = v;
         lat = 3;
      end
   endfunction

   // One transaction: sa stall cycles in ACCESS, sl stall cycles in LOAD_DATA
   task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int sa, input int sl);
      ref_txn(we, f3, addr, wdata, e_rdata, e_mis, e_flt, e_lat);
      if (!(e_mis || e_flt)) e_lat = e_lat + sa + (we ? 0 : sl);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
      bus.req_addr = addr; bus.req_wdata = wdata; bus.mem_available = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
      bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
      o_lat = -1; o_strobe_cycles = 0; o_unstable = 0; o_ready_busy = 0;
      o_wr = 1'b0; o_rd = 1'b0; o_maddr = '0; o_mwdata = '0; o_mctrl = '0;
      o_rdata = '0; o_mis = 1'b0; o_flt = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         bus.mem_available = !((c <= sa) || ((c >= sa + 2) && (c <= sa + 1 + sl)));
         @(negedge clk);
         if (bus.req_ready) o_ready_busy++;
         if (bus.mem_wr_en || bus.mem_rd_en) begin
            if (o_strobe_cycles == 0) begin
               o_wr = bus.mem_wr_en; o_rd = bus.mem_rd_en; o_maddr = bus.mem_addr;
               o_mwdata = bus.mem_wdata; o_mctrl = bus.mem_ctrl;
            end else if ({bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata, bus.mem_ctrl}
                         !== {o_wr, o_rd, o_maddr, o_mwdata, o_mctrl}) begin
               o_unstable++;
            end
            o_strobe_cycles++;
         end else if (o_strobe_cycles > 0 && bus.mem_addr !== o_maddr) begin
            o_unstable++;
         end
         if (bus.rsp_valid) begin
            o_lat = c; o_rdata = bus.rsp_rdata; o_mis = bus.rsp_misaligned; o_flt = bus.rsp_fault;
            break;
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (o_lat < 0) begin
         n_errors++;
         $display("FAIL txn_timeout: no rsp_valid within 60 cycles (addr=%h f3=%b we=%b)", addr, f3, we);
      end
      @(negedge clk);
      o_pulse_ok = !bus.rsp_valid && bus.req_ready && (bus.rsp_rdata === o_rdata)
                   && (bus.rsp_misaligned === o_mis) && (bus.rsp_fault === o_flt);
      bus.mem_available = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_misaligned, bus.rsp_fault, bus.mem_addr,
           bus.mem_wdata, bus.mem_ctrl, bus.mem_wr_en, bus.mem_rd_en} !== 105'b0) begin
         n_errors++;
         $display("FAIL reset_outputs: rsp_rdata=%h mem_addr=%h mem_ctrl=%b expected all zero",
                  bus.rsp_rdata, bus.mem_addr, bus.mem_ctrl);
      end
      n_checks++;
      if (bus.req_ready !== 1'b1) begin
         n_errors++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_word;
      do_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0);
      n_checks++;
      if ({o_lat, o_mctrl, o_maddr, o_mwdata, o_wr, o_rd} !== {32'd2, 4'b1111, 32'h100, 32'hDEADBEEF, 2'b10}) begin
         n_errors++;
         $display("FAIL sw_access: lat=%0d ctrl=%b addr=%h wdata=%h wr/rd=%b%b expected 2 1111 100 deadbeef 10",
                  o_lat, o_mctrl, o_maddr, o_mwdata, o_wr, o_rd);
      end
      do_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 0);
      n_checks++;
      if ({o_lat, o_rdata, o_mis, o_flt, o_wr, o_rd} !== {32'd3, 32'hDEADBEEF, 2'b00, 2'b01}) begin
         n_errors++;
         $display("FAIL lw_read: lat=%0d rdata=%h mis=%b flt=%b wr/rd=%b%b expected 3 deadbeef 0 0 01",
                  o_lat, o_rdata, o_mis, o_flt, o_wr, o_rd);
      end
      n_checks++;
      if (o_pulse_ok !== 1'b1) begin
         n_errors++; $display("FAIL rsp_hold: pulse/hold ok=%b expected 1", o_pulse_ok);
      end
   endtask

   task automatic test_byte;
      do_txn(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0);
      n_checks++;
      if ({o_lat, o_maddr, o_mctrl, o_mwdata[31:24]} !== {32'd2, 32'h100, 4'b1000, 8'hA5}) begin
         n_errors++;
         $display("FAIL sb_access: lat=%0d addr=%h ctrl=%b lane3=%h expected 2 100 1000 a5",
                  o_lat, o_maddr, o_mctrl, o_mwdata[31:24]);
      end
      do_txn(1'b0, 3'b000, 32'h103, 32'h0, 0, 0);
      n_checks++;
      if (o_rdata !== 32'hFFFFFFA5) begin
         n_errors++; $display("FAIL lb_sext: got %h expected ffffffa5", o_rdata);
      end
      do_txn(1'b0, 3'b100, 32'h103, 32'h0, 0, 0);
      n_checks++;
      if (o_rdata !== 32'h000000A5) begin
         n_errors++; $display("FAIL lbu_zext: got %h expected 000000a5", o_rdata);
      end
   endtask

   task automatic test_half;
      do_txn(1'b1, 3'b001, 32'h102, 32'h00008001, 0, 0);
      n_checks++;
      if ({o_mctrl, o_mwdata[31:16]} !== {4'b1100, 16'h8001}) begin
         n_errors++;
         $display("FAIL sh_access: ctrl=%b upper=%h expected 1100 8001", o_mctrl, o_mwdata[31:16]);
      end
      do_txn(1'b0, 3'b001, 32'h102, 32'h0, 0, 0);
      n_checks++;
      if (o_rdata !== 32'hFFFF8001) begin
         n_errors++; $display("FAIL lh_sext: got %h expected ffff8001", o_rdata);
      end
      do_txn(1'b0, 3'b101, 32'h102, 32'h0, 0, 0);
      n_checks++;
      if (o_rdata !== 32'h00008001) begin
         n_errors++; $display("FAIL lhu_zext: got %h expected 00008001", o_rdata);
      end
   endtask

   task automatic test_errors;
      err_case_t cases [5] = '{
         '{we: 1'b0, f3: 3'b010, addr: 32'h101, mis: 1'b1, flt: 1'b0},
         '{we: 1'b1, f3: 3'b001, addr: 32'h0FF, mis: 1'b1, flt: 1'b0},
         '{we: 1'b0, f3: 3'b011, addr: 32'h100, mis: 1'b0, flt: 1'b1},
         '{we: 1'b1, f3: 3'b100, addr: 32'h100, mis: 1'b0, flt: 1'b1},
         '{we: 1'b0, f3: 3'b110, addr: 32'h100, mis: 1'b0, flt: 1'b1}
      };
      for (int i = 0; i < 5; i++) begin
         do_txn(cases[i].we, cases[i].f3, cases[i].addr, 32'h5A5A5A5A, 0, 0);
         n_checks++;
         if ({o_lat, o_mis, o_flt, o_strobe_cycles, o_rdata} !==
             {32'd1, cases[i].mis, cases[i].flt, 32'd0, 32'd0}) begin
            n_errors++;
            $display("FAIL error_case%0d: lat=%0d mis=%b flt=%b strobes=%0d rdata=%h expected 1 %b %b 0 0",
                     i, o_lat, o_mis, o_flt, o_strobe_cycles, o_rdata, cases[i].mis, cases[i].flt);
         end
      end
   endtask

   task automatic test_range;
      do_txn(1'b1, 3'b010, 32'hFFFC, 32'h12345678, 0, 0);
      do_txn(1'b0, 3'b010, 32'hFFFC, 32'h0, 0, 0);
      n_checks++;
      if ({o_lat, o_flt, o_rdata} !== {32'd3, 1'b0, 32'h12345678}) begin
         n_errors++;
         $display("FAIL lw_top: lat=%0d flt=%b rdata=%h expected 3 0 12345678", o_lat, o_flt, o_rdata);
      end
      do_txn(1'b0, 3'b010, 32'h10000, 32'h0, 0, 0);
      n_checks++;
      if ({o_lat, o_mis, o_flt, o_strobe_cycles} !== {32'd1, 2'b01, 32'd0}) begin
         n_errors++;
         $display("FAIL lw_oor: lat=%0d mis=%b flt=%b strobes=%0d expected 1 0 1 0",
                  o_lat, o_mis, o_flt, o_strobe_cycles);
      end
      do_txn(1'b0, 3'b001, 32'hFFFF, 32'h0, 0, 0);
      n_checks++;
      if ({o_lat, o_mis, o_flt, o_strobe_cycles} !== {32'd1, 2'b10, 32'd0}) begin
         n_errors++;
         $display("FAIL lh_top_mis: lat=%0d mis=%b flt=%b strobes=%0d expected 1 1 0 0",
                  o_lat, o_mis, o_flt, o_strobe_cycles);
      end
      do_txn(1'b0, 3'b100, 32'hFFFF, 32'h0, 0, 0);
      n_checks++;
      if ({o_lat, o_flt, o_rdata} !== {32'd3, 1'b0, 32'h00000012}) begin
         n_errors++;
         $display("FAIL lbu_last_byte: lat=%0d flt=%b rdata=%h expected 3 0 00000012", o_lat, o_flt, o_rdata);
      end
   endtask

   task automatic test_stall;
      do_txn(1'b1, 3'b010, 32'h140, 32'hCAFEF00D, 3, 0);
      n_checks++;
      if ({o_lat, o_strobe_cycles, o_unstable} !== {32'd5, 32'd4, 32'd0}) begin
         n_errors++;
         $display("FAIL stall_store: lat=%0d strobes=%0d unstable=%0d expected 5 4 0",
                  o_lat, o_strobe_cycles, o_unstable);
      end
      do_txn(1'b0, 3'b010, 32'h140, 32'h0, 3, 2);
      n_checks++;
      if ({o_lat, o_strobe_cycles, o_unstable, o_rdata} !== {32'd8, 32'd4, 32'd0, 32'hCAFEF00D}) begin
         n_errors++;
         $display("FAIL stall_load: lat=%0d strobes=%0d unstable=%0d rdata=%h expected 8 4 0 cafef00d",
                  o_lat, o_strobe_cycles, o_unstable, o_rdata);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] er;
      logic        em, ef;
      int          el, lat;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h101;
      @(posedge clk); #1;
      bus.req_addr = 32'h100;
      @(negedge clk);
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_misaligned, bus.req_ready} !== 3'b110) begin
         n_errors++;
         $display("FAIL b2b_resp: valid/mis/ready=%b%b%b expected 110",
                  bus.rsp_valid, bus.rsp_misaligned, bus.req_ready);
      end
      @(negedge clk);
      n_checks++;
      if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
         n_errors++;
         $display("FAIL b2b_idle: valid/ready=%b%b expected 01", bus.rsp_valid, bus.req_ready);
      end
      ref_txn(1'b0, 3'b010, 32'h100, 32'h0, er, em, ef, el);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin lat = c; break; end
      end
      n_checks++;
      if ({lat, bus.rsp_rdata, bus.rsp_misaligned, bus.rsp_fault} !== {el, er, em, ef}) begin
         n_errors++;
         $display("FAIL b2b_second: lat=%0d rdata=%h mis=%b flt=%b expected %0d %h %b %b",
                  lat, bus.rsp_rdata, bus.rsp_misaligned, bus.rsp_fault, el, er, em, ef);
      end
   endtask

   task automatic test_random;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic        we;
      int          sa, sl, r, exp_strobes;
      logic [2:0]  legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      for (int n = 0; n < 250; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7)      addr = 32'h200 + $urandom_range(0, 63);
         else if (r < 9) addr = 32'hFFF0 + $urandom_range(0, 19);
         else            addr = $urandom;
         f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
         we = 1'($urandom);
         sa = int'($urandom_range(0, 2));
         sl = int'($urandom_range(0, 2));
         do_txn(we, f3, addr, $urandom, sa, sl);
         exp_strobes = (e_mis || e_flt) ? 0 : sa + 1;
         n_checks++;
         if ({o_rdata, o_mis, o_flt} !== {e_rdata, e_mis, e_flt}) begin
            n_errors++;
            $display("FAIL rand_rsp[%0d]: we=%b f3=%b addr=%h got rdata=%h mis=%b flt=%b expected %h %b %b",
                     n, we, f3, addr, o_rdata, o_mis, o_flt, e_rdata, e_mis, e_flt);
         end
         n_checks++;
         if (o_lat !== e_lat) begin
            n_errors++;
            $display("FAIL rand_lat[%0d]: got %0d expected %0d", n, o_lat, e_lat);
         end
         n_checks++;
         if ({o_strobe_cycles, o_unstable, o_ready_busy} !== {exp_strobes, 32'd0, 32'd0}) begin
            n_errors++;
            $display("FAIL rand_bus[%0d]: strobes=%0d unstable=%0d ready_busy=%0d expected %0d 0 0",
                     n, o_strobe_cycles, o_unstable, o_ready_busy, exp_strobes);
         end
         n_checks++;
         if (o_pulse_ok !== 1'b1) begin
            n_errors++; $display("FAIL rand_pulse[%0d]: pulse/hold ok=%b expected 1", n, o_pulse_ok);
         end
      end
   endtask

   task automatic test_reset_mid;
      int seen;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h140; bus.mem_available = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      bus.mem_available = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_misaligned, bus.rsp_fault, bus.mem_addr,
           bus.mem_wdata, bus.mem_ctrl, bus.mem_wr_en, bus.mem_rd_en, bus.req_ready} !== {105'b0, 1'b1}) begin
         n_errors++;
         $display("FAIL reset_mid_outputs: mem_addr=%h rsp_rdata=%h ready=%b expected 0 0 1",
                  bus.mem_addr, bus.rsp_rdata, bus.req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_available = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.rsp_valid) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_errors++; $display("FAIL reset_mid_no_rsp: saw %0d rsp_valid cycles expected 0", seen);
      end
      do_txn(1'b0, 3'b010, 32'h140, 32'h0, 0, 0);
      n_checks++;
      if ({o_lat, o_rdata} !== {e_lat, e_rdata}) begin
         n_errors++;
         $display("FAIL reset_mid_recover: lat=%0d rdata=%h expected %0d %h", o_lat, o_rdata, e_lat, e_rdata);
      end
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
      bus.req_addr = '0; bus.req_wdata = '0; bus.mem_available = 1'b1;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_errors();
      test_range();
      test_stall();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lsu_data_port.md
Name: lsu_data_port

Overview:
- Initiator-side load/store unit between the core's memory stage and the byte-addressed data memory.
- Accepts one load/store request per transaction and checks alignment and range.
- Drives a word-aligned address, per-lane write strobes and lane-shifted store data to the memory.
- Captures the memory's registered read word, extracts and sign/zero-extends the loaded byte/half/word, and returns a single-cycle response.

Parameters:
ADDR_LIMIT, 65536, memory size in bytes; any access with addr + access_size > ADDR_LIMIT faults.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_misaligned  out  1  valid with rsp_valid
rsp_fault  out  1  valid with rsp_valid; out-of-range address or illegal funct3
mem_addr  out  32  {addr[31:2],2'b00}
mem_wdata  out  32  store data shifted into its byte lanes
mem_ctrl  out  4  byte-lane strobe; bit k writes mem_addr+k
mem_wr_en  out  1  store strobe
mem_rd_en  out  1  load strobe
mem_rdata  in  32  memory read word, registered by the memory, valid the cycle after the address
mem_available  in  1  memory ready; 0 stalls the current state

Behaviour:
- Reset (async):
  - State = IDLE.
  - rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault, mem_addr, mem_wdata, mem_ctrl, mem_wr_en and mem_rd_en all = 0.
  - req_ready = 1.
  - Reset mid-transaction abandons it with no response. A store is never partially re-issued after reset.
- States: IDLE, ACCESS, LOAD_DATA, RESP.
- IDLE:
  - On acceptance, register addr, we, funct3 and wdata.
  - Illegal funct3 (011, 110, 111; or 1xx with we) -> RESP, fault=1.
  - Misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0) -> RESP, misaligned=1.
  - Out of range -> RESP, fault=1.
  - Misaligned takes priority over out of range.
  - Error paths never assert mem_wr_en or mem_rd_en.
  - Otherwise -> ACCESS.
- ACCESS:
  - mem_addr, mem_ctrl and mem_wdata driven from registered values; exactly one of mem_wr_en/mem_rd_en = 1.
  - Strobes: B/BU = 4'b0001 << addr[1:0]; H/HU = 4'b0011 << {addr[1],1'b0}; W = 4'b1111.
  - mem_wdata = wdata << (8*addr[1:0]); unused lanes are don't-care but driven deterministically.
  - mem_available = 0: hold ACCESS with all mem_* outputs stable.
  - mem_available = 1: store -> RESP; load -> LOAD_DATA.
- LOAD_DATA:
  - mem_rd_en = 0; mem_addr held.
  - When mem_available = 1, register rsp_rdata from mem_rdata and go -> RESP. Otherwise hold.
  - Extraction:
    - LB: sign-extend byte[8*off+:8].
    - LBU: zero-extend the same byte.
    - LH: sign-extend half[16*addr[1]+:16].
    - LHU: zero-extend the same half.
    - LW: full word.
- RESP:
  - rsp_valid = 1 for exactly one cycle; error flags valid.
  - Next state IDLE; req_ready = 0 during RESP.
- Latency (mem_available = 1):
  - Store: rsp_valid 2 cycles after acceptance.
  - Load: rsp_valid 3 cycles after acceptance.
  - Error: rsp_valid 1 cycle after acceptance.
- rsp_* outputs hold their last values after the pulse. All of them clear on the next acceptance.
- At most one outstanding transaction; requests outside IDLE are not accepted and are not lost.

Test Plan:
- SW 0xDEADBEEF @0x100 then LW @0x100 -> ACCESS: mem_ctrl=4'b1111, mem_addr=0x100; load rsp_rdata=0xDEADBEEF; rsp_valid at +2 / +3 cycles.
- SB 0xA5 @0x103 -> mem_addr=0x100, mem_ctrl=4'b1000, mem_wdata[31:24]=0xA5; then LB @0x103 -> 0xFFFFFFA5, and LBU @0x103 -> 0x000000A5.
- SH 0x8001 @0x102 -> mem_ctrl=4'b1100; then LH @0x102 -> 0xFFFF8001, and LHU -> 0x00008001.
- LW @0x101, SH @0x0FF and funct3=011 -> rsp_valid 1 cycle after acceptance; misaligned/misaligned/fault respectively; mem_wr_en and mem_rd_en never asserted; rdata=0.
- LW @0xFFFC ok; LW @0x10000 and LH @0xFFFF -> LW @0x10000: rsp_fault=1; LH @0xFFFF: rsp_misaligned=1, rsp_fault=0; no memory strobes.
- mem_available low 3 cycles in ACCESS and 2 in LOAD_DATA -> outputs stable, latency stretched by 5 cycles; rst_n pulsed in LOAD_DATA -> IDLE, all outputs 0, no rsp_valid.
